// File: rtl/mem_access_seq.sv
// mem_access_seq: one load/store per handshake to a fixed-latency synchronous memory, with lane steering, extension and alignment checking
module mem_access_seq #(
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset_signal,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  localparam logic [2:0] RD_L = 3'(RD_LATENCY - 1);
  localparam logic [2:0] WR_L = 3'(WR_LATENCY - 1);
  state_t state;
  logic [2:0] cnt;
  logic wr_q, sign_q, accept, mis;
  logic [1:0] size_q, off_q;
  logic [3:0] lanes;
  logic [31:0] wrep, sh, ext;
  assign req_ready = (state == IDLE) & Reset_signal;
  assign busy = state != IDLE;
  assign accept = req_valid & req_ready;
  always_comb begin
    mis = (req_size == 2'd3) | ((req_size == 2'd1) & req_addr[0]) | ((req_size == 2'd2) & (|req_addr[1:0]));
    lanes = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] : req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = req_size == 2'd0 ? {4{req_wdata[7:0]}} : req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    sh = mem_rdata >> {off_q, 3'b000};
    ext = size_q == 2'd0 ? {{24{sign_q & sh[7]}}, sh[7:0]} : size_q == 2'd1 ? {{16{sign_q & sh[15]}}, sh[15:0]} : mem_rdata;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_signal) begin
      state <= IDLE;
      cnt <= 3'd0;
      wr_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr <= 32'd0;
      mem_wr <= 1'b0;
      mem_byte_en <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wr_q <= req_wr;
          sign_q <= req_sign;
          size_q <= req_size;
          off_q <= req_addr[1:0];
          if (mis) begin
            state <= ERR;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            state <= ACCESS;
            cnt <= req_wr ? WR_L : RD_L;
            mem_addr <= {req_addr[31:2], 2'b00};
            mem_byte_en <= lanes;
            mem_wr <= req_wr;
            mem_wdata <= wrep;
          end
        end
        ACCESS: if (cnt == 3'd0) begin
          state <= RESP;
          mem_wr <= 1'b0;
          mem_byte_en <= 4'd0;
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          resp_rdata <= wr_q ? 32'd0 : ext;
        end else begin
          cnt <= cnt - 3'd1;
        end
        default: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed vectors, randomized transactions against a reference model, and a reset-abort sequence
module tb_mem_access_seq;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic rst1, rst2, req_valid, req_wr, req_sign, sel;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic rdy1, rv1, re1, busy1, mw1, rdy2, rv2, re2, busy2, mw2;
  logic [31:0] rd1, ma1, wd1, rd2, ma2, wd2;
  logic [3:0] be1, be2;
  logic o_rdy, o_rv, o_re, o_busy, o_mw;
  logic [31:0] o_rd, o_ma, o_wd;
  logic [3:0] o_be;
  int n_cmp = 0, n_bad = 0;

  mem_access_seq u1 (
    .Clk(Clk), .Reset_signal(rst1), .req_valid(req_valid), .req_ready(rdy1), .req_wr(req_wr),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1), .busy(busy1), .mem_addr(ma1),
    .mem_wr(mw1), .mem_byte_en(be1), .mem_wdata(wd1), .mem_rdata(mem_rdata));
  mem_access_seq #(.WR_LATENCY(3)) u2 (
    .Clk(Clk), .Reset_signal(rst2), .req_valid(req_valid), .req_ready(rdy2), .req_wr(req_wr),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_err(re2), .resp_rdata(rd2), .busy(busy2), .mem_addr(ma2),
    .mem_wr(mw2), .mem_byte_en(be2), .mem_wdata(wd2), .mem_rdata(mem_rdata));

  assign o_rdy = sel ? rdy2 : rdy1;
  assign o_rv = sel ? rv2 : rv1;
  assign o_re = sel ? re2 : re1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_mw = sel ? mw2 : mw1;
  assign o_rd = sel ? rd2 : rd1;
  assign o_ma = sel ? ma2 : ma1;
  assign o_wd = sel ? wd2 : wd1;
  assign o_be = sel ? be2 : be1;

  typedef struct {
    logic wr; logic [1:0] sz; logic sg; logic [31:0] ad, wd, rd;
    logic err; logic [3:0] be; logic [31:0] ewd, erd;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    req_valid = 1'($urandom);
    req_wr = 1'($urandom);
    req_size = 2'($urandom);
    req_sign = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  // Expected results from byte-count arithmetic rather than the lane muxes
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                                output logic err, output logic [3:0] be,
                                output logic [31:0] ewd, output logic [31:0] erd);
    int n, off;
    longint mask, v;
    n = 1 << sz;
    off = int'(ad % 4);
    err = (sz == 2'd3) || (ad % n != 0);
    be = err ? 4'd0 : 4'(((1 << n) - 1) << off);
    ewd = 32'd0;
    erd = 32'd0;
    if (!err) begin
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
      mask = (longint'(1) << (8 * n)) - 1;
      v = (longint'(rd) >> (8 * off)) & mask;
      if (sg && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
      erd = wr ? 32'd0 : v[31:0];
    end
  endfunction

  // Starts and ends at a negedge with the selected DUT idle
  task automatic do_txn(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                        input logic e_err, input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_rd);
    int lat;
    lat = wr ? (sel ? 3 : 1) : 2;
    chk({nm, " ready"}, 32'(o_rdy), 32'd1);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_sign = sg;
    req_addr = ad; req_wdata = wd; mem_rdata = rd;
    @(negedge Clk);
    scramble();
    if (e_err) begin
      chk({nm, " err resp"}, {o_rv, o_re, o_busy}, 3'b111);
      chk({nm, " err rdata"}, o_rd, 32'd0);
      chk({nm, " err nomem"}, {o_mw, o_be}, 5'd0);
    end else begin
      for (int k = 0; k < lat; k++) begin
        chk($sformatf("%s acc%0d ctl", nm, k), {o_busy, o_mw, o_be, o_rv}, {1'b1, wr, e_be, 1'b0});
        chk($sformatf("%s acc%0d addr", nm, k), o_ma, ad & 32'hFFFF_FFFC);
        if (wr) chk($sformatf("%s acc%0d wdata", nm, k), o_wd, e_wd);
        @(negedge Clk);
        scramble();
      end
      chk({nm, " resp"}, {o_rv, o_re, o_mw, o_be}, {1'b1, 1'b0, 1'b0, 4'd0});
      chk({nm, " rdata"}, o_rd, e_rd);
    end
    @(negedge Clk);
    req_valid = 1'b0;
    chk({nm, " after"}, {o_rdy, o_rv, o_busy}, 3'b100);
  endtask

  initial begin
    logic e_err, wr, sg, seen;
    logic [1:0] sz;
    logic [3:0] e_be;
    logic [31:0] ad, wd, rd, e_wd, e_rd;
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 1'b0, 4'hC, 32'h0, 32'h000080FF});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h101, 32'h55, 32'h0, 1'b0, 4'h2, 32'h55555555, 32'h0});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h106, 32'h1234ABCD, 32'h0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h0000F00D, 1'b0, 4'h3, 32'h0, 32'hFFFFF00D});
    vt.push_back('{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'hABCDEFC3, 1'b0, 4'h1, 32'h0, 32'h000000C3});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h101, 32'h1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h204, 32'h01234567, 32'h0, 1'b0, 4'hF, 32'h01234567, 32'h0});
    sel = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0;
    repeat (2) @(negedge Clk);
    chk("reset ctl", {rdy1, rv1, re1, busy1, mw1, be1}, 9'd0);
    chk("reset addr", ma1, 32'd0);
    chk("reset wdata", wd1, 32'd0);
    chk("reset rdata", rd1, 32'd0);
    rst1 = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < vt.size(); i++)
      do_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].sz, vt[i].sg, vt[i].ad, vt[i].wd, vt[i].rd,
             vt[i].err, vt[i].be, vt[i].ewd, vt[i].erd);
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom); sz = 2'($urandom_range(0, 3)); sg = 1'($urandom);
      ad = $urandom; wd = $urandom; rd = $urandom;
      model(wr, sz, sg, ad, wd, rd, e_err, e_be, e_wd, e_rd);
      do_txn($sformatf("rnd%0d", i), wr, sz, sg, ad, wd, rd, e_err, e_be, e_wd, e_rd);
    end
    // Store with 3-cycle write latency, aborted by reset during its second access cycle
    sel = 1'b1; rst1 = 1'b0; rst2 = 1'b1;
    @(negedge Clk);
    chk("abort ready", 32'(o_rdy), 32'd1);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    @(negedge Clk);
    req_valid = 1'b0;
    chk("abort acc0", {o_mw, o_be}, 5'b11111);
    chk("abort addr", o_ma, 32'h200);
    chk("abort wdata", o_wd, 32'hCAFEF00D);
    @(negedge Clk);
    chk("abort acc1", 32'(o_mw), 32'd1);
    rst2 = 1'b0;
    @(negedge Clk);
    chk("abort cleared", {o_mw, o_be, o_rv, o_busy, o_rdy}, 8'd0);
    rst2 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (o_rv) seen = 1'b1;
    end
    chk("abort no resp", 32'(seen), 32'd0);
    do_txn("post abort", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
